// File: rtl/reg_dump_uart_pkg.sv
// Shared definitions for the register-dump UART: state encodings, mux select
// codes and frame defaults.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_SEL   = 3'd4
    } state_t;

    // Sequencer view of the frame: idle, byte on the line, or mux settling.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_SEND = 2'd1,
        SEQ_SEL  = 2'd2
    } seq_t;

    localparam logic [2:0] SEL_A   = 3'd0;
    localparam logic [2:0] SEL_MDR = 3'd1;
    localparam logic [2:0] SEL_IMM = 3'd2;
    localparam logic [2:0] SEL_Y   = 3'd3;
    localparam logic [2:0] SEL_X   = 3'd4;

    localparam logic [7:0] DEFAULT_HEADER   = 8'hA5;
    localparam int         DEFAULT_NUM_REGS = 5;

    // Baud counter width; a divider of 1 still needs a 1-bit counter.
    function automatic int baud_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/reg_dump_uart_tx.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
// `done` flags the last cycle of the stop bit so the caller can chain bytes.
module uart_tx_byte
    import reg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int             CW        = baud_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_last_s;

    assign baud_last_s = (baud_q == BAUD_LAST);
    assign tx          = tx_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_STOP) && baud_last_s;

    // State, counters and line register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Bit sequencing; tx_d is the level for the cycle after the edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    shift_d = data;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    state_d = ST_IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/reg_dump_uart.sv
// Register dump sequencer: sends HEADER then each datapath register, stepping
// SELECT_OUT and snapshotting the mux bus one cycle after each select change.
module reg_dump_uart
    import reg_dump_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         NUM_REGS     = DEFAULT_NUM_REGS,
    parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DUMP_REQ,
    input  logic [7:0] OUT_DATA_BUS_to_FPGA,
    output logic [2:0] SELECT_OUT,
    output logic       UART_TX,
    output logic       BUSY,
    output logic       DONE
);

    seq_t       seq_q, seq_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       start_s;
    logic [7:0] byte_s;
    logic       tx_busy_s;
    logic       tx_done_s;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (CLK),
        .rst  (RST),
        .start(start_s),
        .data (byte_s),
        .tx   (UART_TX),
        .busy (tx_busy_s),
        .done (tx_done_s)
    );

    assign SELECT_OUT = sel_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

    // Sequencer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seq_q  <= SEQ_IDLE;
            idx_q  <= 3'd0;
            sel_q  <= SEL_A;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Frame sequencing: header, then one SEL settle cycle before each register.
    always_comb begin
        seq_d   = seq_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        start_s = 1'b0;
        byte_s  = HEADER;
        case (seq_q)
            SEQ_IDLE: begin
                if (DUMP_REQ && !tx_busy_s) begin
                    seq_d   = SEQ_SEND;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    start_s = 1'b1;
                end else begin
                    seq_d   = SEQ_IDLE;
                end
            end
            SEQ_SEND: begin
                if (!tx_done_s) begin
                    seq_d = SEQ_SEND;
                end else if (idx_q < 3'(NUM_REGS)) begin
                    seq_d = SEQ_SEL;
                    sel_d = idx_q;
                end else begin
                    seq_d  = SEQ_IDLE;
                    sel_d  = SEL_A;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            SEQ_SEL: begin
                seq_d   = SEQ_SEND;
                idx_d   = idx_q + 3'd1;
                start_s = 1'b1;
                byte_s  = OUT_DATA_BUS_to_FPGA;
            end
            default: begin
                seq_d  = SEQ_IDLE;
                sel_d  = SEL_A;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_uart.sv
// Directed bench for reg_dump_uart: divider 4 instance for most scenarios,
// divider 1 instance for the minimum-divider frame.
module tb_reg_dump_uart;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, req4, tx4, busy4, done4;
    logic [2:0] sel4;
    logic [7:0] bus4;
    logic       rst1, req1, tx1, busy1, done1;
    logic [2:0] sel1;
    logic [7:0] bus1;

    logic [7:0] regs [0:7];
    assign bus4 = regs[sel4];
    assign bus1 = regs[sel1];

    reg_dump_uart #(.CLKS_PER_BIT(4)) dut4 (
        .CLK(clk), .RST(rst4), .DUMP_REQ(req4), .OUT_DATA_BUS_to_FPGA(bus4),
        .SELECT_OUT(sel4), .UART_TX(tx4), .BUSY(busy4), .DONE(done4)
    );

    reg_dump_uart #(.CLKS_PER_BIT(1)) dut1 (
        .CLK(clk), .RST(rst1), .DUMP_REQ(req1), .OUT_DATA_BUS_to_FPGA(bus1),
        .SELECT_OUT(sel1), .UART_TX(tx1), .BUSY(busy1), .DONE(done1)
    );

    typedef struct {
        logic       rst;
        logic       req;
        logic       tx;
        logic       busy;
        logic       done;
        logic [2:0] sel;
    } rst_vec_t;

    typedef struct {
        int         cyc;
        logic       tx;
        logic       busy;
        logic       done;
        logic [2:0] sel;
    } tp_vec_t;

    rst_vec_t rv [0:7];
    tp_vec_t  tp [0:15];

    logic       trace_tx   [0:319];
    logic       trace_busy [0:319];
    logic       trace_done [0:319];
    logic [2:0] trace_sel  [0:319];
    logic [7:0] dec_bytes  [0:7];
    logic [7:0] exp_bytes  [0:5];
    int         dec_count;
    logic       stop_ok;
    int         total;
    int         passed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit c1, input logic v);
        if (c1) req1 = v; else req4 = v;
    endtask

    task automatic set_rst(input bit c1, input logic v);
        if (c1) rst1 = v; else rst4 = v;
    endtask

    // Start a frame at edge 0 and record outputs of cycles 0..n-1.
    task automatic capture(input bit c1, input int n, input bit hold,
                           input int poke_cyc, input int req_cyc, input int rst_cyc);
        set_req(c1, 1'b1);
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            trace_tx[k]   = c1 ? tx1   : tx4;
            trace_busy[k] = c1 ? busy1 : busy4;
            trace_done[k] = c1 ? done1 : done4;
            trace_sel[k]  = c1 ? sel1  : sel4;
            if (k == 0 && !hold) set_req(c1, 1'b0);
            if (k == poke_cyc) regs[0] = 8'hFF;
            if (k == req_cyc) set_req(c1, 1'b1);
            if (k == req_cyc + 1 && !hold) set_req(c1, 1'b0);
            if (k == rst_cyc) set_rst(c1, 1'b1);
            if (k == rst_cyc + 1) set_rst(c1, 1'b0);
        end
    endtask

    // Decode 8N1 bytes from the recorded line, sampling mid-bit.
    task automatic decode_all(input int c, input int n);
        int pos;
        int s;
        dec_count = 0;
        stop_ok   = 1'b1;
        pos       = 0;
        while (dec_count < 8) begin
            s = -1;
            for (int i = pos; i < n; i++) begin
                if (s < 0 && trace_tx[i] == 1'b0) s = i;
            end
            if (s < 0 || s + 10 * c > n) break;
            for (int b = 0; b < 8; b++) begin
                dec_bytes[dec_count][b] = trace_tx[s + c * (1 + b) + c / 2];
            end
            if (trace_tx[s + 9 * c + c / 2] !== 1'b1) stop_ok = 1'b0;
            dec_count = dec_count + 1;
            pos = s + 10 * c;
        end
    endtask

    // Common frame checks: bytes, stop bits, single DONE, BUSY window.
    task automatic check_frame(input string tag, input int c, input int n, input int done_cyc);
        int dn;
        int dpos;
        int bz;
        decode_all(c, n);
        check({tag, "_byte_count"}, dec_count, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'h0, dec_bytes[i]}, {24'h0, exp_bytes[i]});
        end
        check({tag, "_stop_bits"}, {31'h0, stop_ok}, 32'd1);
        dn = 0;
        dpos = -1;
        bz = 0;
        for (int k = 0; k < n; k++) begin
            if (trace_done[k] === 1'b1) begin
                dn = dn + 1;
                dpos = k;
            end
            if (k < done_cyc && trace_busy[k] !== 1'b1) bz = bz + 1;
            if (k >= done_cyc && trace_busy[k] !== 1'b0) bz = bz + 1;
        end
        check({tag, "_done_count"}, dn, 1);
        check({tag, "_done_cycle"}, dpos, done_cyc);
        check({tag, "_busy_window_errs"}, bz, 0);
    endtask

    initial begin
        int bad;
        total  = 0;
        passed = 0;
        rst4 = 1'b1; req4 = 1'b1;
        rst1 = 1'b1; req1 = 1'b0;
        regs[0] = 8'h12; regs[1] = 8'h34; regs[2] = 8'h56; regs[3] = 8'h78;
        regs[4] = 8'h9A; regs[5] = 8'h00; regs[6] = 8'h00; regs[7] = 8'h00;
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h12; exp_bytes[2] = 8'h34;
        exp_bytes[3] = 8'h56; exp_bytes[4] = 8'h78; exp_bytes[5] = 8'h9A;

        // rst, req -> tx, busy, done, sel
        rv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        rv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        rv[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        rv[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
        rv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        rv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        rv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        rv[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

        // Full dump at divider 4: cycle -> tx, busy, done, sel
        tp[0]  = '{0,   1'b0, 1'b1, 1'b0, 3'd0};
        tp[1]  = '{4,   1'b1, 1'b1, 1'b0, 3'd0};
        tp[2]  = '{8,   1'b0, 1'b1, 1'b0, 3'd0};
        tp[3]  = '{36,  1'b1, 1'b1, 1'b0, 3'd0};
        tp[4]  = '{40,  1'b1, 1'b1, 1'b0, 3'd0};
        tp[5]  = '{41,  1'b0, 1'b1, 1'b0, 3'd0};
        tp[6]  = '{45,  1'b0, 1'b1, 1'b0, 3'd0};
        tp[7]  = '{49,  1'b1, 1'b1, 1'b0, 3'd0};
        tp[8]  = '{61,  1'b1, 1'b1, 1'b0, 3'd0};
        tp[9]  = '{81,  1'b1, 1'b1, 1'b0, 3'd1};
        tp[10] = '{122, 1'b1, 1'b1, 1'b0, 3'd2};
        tp[11] = '{163, 1'b1, 1'b1, 1'b0, 3'd3};
        tp[12] = '{204, 1'b1, 1'b1, 1'b0, 3'd4};
        tp[13] = '{244, 1'b1, 1'b1, 1'b0, 3'd4};
        tp[14] = '{245, 1'b1, 1'b0, 1'b1, 3'd0};
        tp[15] = '{246, 1'b1, 1'b0, 1'b0, 3'd0};

        @(negedge clk);
        // Reset behaviour and reset-over-request priority.
        for (int i = 0; i < 8; i++) begin
            rst4 = rv[i].rst;
            req4 = rv[i].req;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("reset_vec%0d", i), {26'h0, tx4, busy4, done4, sel4},
                  {26'h0, rv[i].tx, rv[i].busy, rv[i].done, rv[i].sel});
        end

        // Full dump.
        capture(1'b0, 250, 1'b0, -1, -1, -1);
        check_frame("full", 4, 250, 245);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_tp%0d", tp[i].cyc),
                  {26'h0, trace_tx[tp[i].cyc], trace_busy[tp[i].cyc], trace_done[tp[i].cyc], trace_sel[tp[i].cyc]},
                  {26'h0, tp[i].tx, tp[i].busy, tp[i].done, tp[i].sel});
        end

        // Snapshot: A changes two cycles after its capture edge (edge 41).
        capture(1'b0, 250, 1'b0, 43, -1, -1);
        decode_all(4, 250);
        check("snap_count", dec_count, 6);
        check("snap_byte_a", {24'h0, dec_bytes[1]}, 32'h12);
        regs[0] = 8'h12;

        // Re-pulse during the IMM byte is ignored.
        capture(1'b0, 300, 1'b0, -1, 130, -1);
        decode_all(4, 300);
        check("repulse_count", dec_count, 6);
        bad = 0;
        for (int k = 246; k < 300; k++) if (trace_busy[k] !== 1'b0) bad = bad + 1;
        check("repulse_no_second_frame", bad, 0);

        // Request held high: second frame begins in cycle 246.
        capture(1'b0, 250, 1'b1, -1, -1, -1);
        check("hold_done245", {30'h0, trace_done[245], trace_busy[245]}, 32'd2);
        check("hold_restart246", {30'h0, trace_busy[246], trace_tx[246]}, 32'd2);
        req4 = 1'b0;
        rst4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;

        // Reset during DATA of the Y byte (RST seen at edge 176).
        capture(1'b0, 260, 1'b0, -1, -1, 175);
        check("midrst_before", {31'h0, trace_tx[175]}, 32'd0);
        check("midrst_after", {27'h0, trace_tx[176], trace_busy[176], trace_sel[176]}, {27'h0, 1'b1, 1'b0, 3'd0});
        bad = 0;
        for (int k = 0; k < 260; k++) if (trace_done[k] === 1'b1) bad = bad + 1;
        for (int k = 176; k < 260; k++) if (trace_busy[k] !== 1'b0 || trace_tx[k] !== 1'b1) bad = bad + 1;
        check("midrst_quiet", bad, 0);
        capture(1'b0, 250, 1'b0, -1, -1, -1);
        check_frame("after_rst", 4, 250, 245);

        // Minimum divider.
        rst1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("c1_idle", {27'h0, tx1, busy1, sel1}, {27'h0, 1'b1, 1'b0, 3'd0});
        capture(1'b1, 70, 1'b0, -1, -1, -1);
        check_frame("c1", 1, 70, 65);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
